// File: rtl/core_pkg.sv
// =============================================================================
// Module      : core_pkg
// Description : Shared core types and constants for the write-back path.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/scoreboard.sv
// =============================================================================
// Module      : scoreboard
// Description : Pending-load bit vector with one set port, one clear port and
//               two combinational read ports. Entry 0 never becomes pending.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module scoreboard
    import core_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rd_idx_a,
    input  reg_idx_t rd_idx_b,
    output logic     busy_a,
    output logic     busy_b
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clear is applied before set so a same-cycle set of the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            pending_nxt[set_idx] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy_a = pending[rd_idx_a];
    assign busy_b = pending[rd_idx_b];

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// =============================================================================
// Module      : writeback_unit
// Description : Round-robin arbiter of ALU/LSU results onto the registered
//               register-file write port, plus pending-load scoreboard.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module writeback_unit
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    input  reg_idx_t        alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  reg_idx_t        lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    output logic            lsu_ready_o,
    input  logic            issue_i,
    input  reg_idx_t        issue_rd_i,
    input  reg_idx_t        chk_rs1_i,
    input  reg_idx_t        chk_rs2_i,
    output logic            busy_rs1_o,
    output logic            busy_rs2_o,
    output logic            we_o,
    output reg_idx_t        sel_rd_o,
    output logic [XLEN-1:0] rd_o
);

    wb_src_e         last_grant;
    logic            contested;
    logic            grant_alu;
    logic            grant_lsu;
    logic            xfer;
    reg_idx_t        xfer_rd;
    logic [XLEN-1:0] xfer_data;

    // Ready is derived from valids and history only, never from data.
    assign contested = alu_valid_i & lsu_valid_i;
    assign grant_alu = alu_valid_i & (~lsu_valid_i | (last_grant == WB_LSU));
    assign grant_lsu = lsu_valid_i & ~grant_alu;
    assign xfer      = grant_alu | grant_lsu;
    assign xfer_rd   = grant_alu ? alu_rd_i   : lsu_rd_i;
    assign xfer_data = grant_alu ? alu_data_i : lsu_data_i;

    assign alu_ready_o = grant_alu;
    assign lsu_ready_o = grant_lsu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= WB_LSU;
            we_o       <= 1'b0;
            sel_rd_o   <= '0;
            rd_o       <= '0;
        end else begin
            if (contested) begin
                last_grant <= grant_alu ? WB_ALU : WB_LSU;
            end
            // Writes to x0 are consumed but leave the port's index/data untouched.
            we_o <= xfer && (xfer_rd != '0);
            if (xfer && (xfer_rd != '0)) begin
                sel_rd_o <= xfer_rd;
                rd_o     <= xfer_data;
            end
        end
    end

    scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_i),
        .set_idx  (issue_rd_i),
        .clr_en   (grant_lsu),
        .clr_idx  (lsu_rd_i),
        .rd_idx_a (chk_rs1_i),
        .rd_idx_b (chk_rs2_i),
        .busy_a   (busy_rs1_o),
        .busy_b   (busy_rs2_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// =============================================================================
// Module      : tb_writeback_unit
// Description : Directed scenarios plus randomized run against a behavioural
//               model of the write-back unit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  chk_rs1_i;
    logic [4:0]  chk_rs2_i;
    logic        busy_rs1_o;
    logic        busy_rs2_o;
    logic        we_o;
    logic [4:0]  sel_rd_o;
    logic [31:0] rd_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .NREG(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .alu_ready_o (alu_ready_o),
        .lsu_valid_i (lsu_valid_i),
        .lsu_rd_i    (lsu_rd_i),
        .lsu_data_i  (lsu_data_i),
        .lsu_ready_o (lsu_ready_o),
        .issue_i     (issue_i),
        .issue_rd_i  (issue_rd_i),
        .chk_rs1_i   (chk_rs1_i),
        .chk_rs2_i   (chk_rs2_i),
        .busy_rs1_o  (busy_rs1_o),
        .busy_rs2_o  (busy_rs2_o),
        .we_o        (we_o),
        .sel_rd_o    (sel_rd_o),
        .rd_o        (rd_o)
    );

    task automatic idle();
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
        issue_i = 1'b0; issue_rd_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        chk_rs1_i = 5'd4; chk_rs2_i = 5'd0;
        apply_reset();
        checks++;
        if (we_o !== 1'b0 || sel_rd_o !== 5'd0 || rd_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b sel=%0d rd=%h, want 0/0/0", we_o, sel_rd_o, rd_o);
        end
        issue_i = 1'b1; issue_rd_i = 5'd4;
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'hAA;
        tick();
        idle();
        #1;
        checks++;
        if (busy_rs1_o !== 1'b1 || we_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b we=%b, want 1/1", busy_rs1_o, we_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (we_o !== 1'b0 || sel_rd_o !== 5'd0 || rd_o !== 32'd0 || busy_rs1_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b sel=%0d rd=%h busy=%b, want all 0",
                     we_o, sel_rd_o, rd_o, busy_rs1_o);
        end
        tick();
        rst = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd1;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL first_contest: alu_ready=%b lsu_ready=%b, want 1/0", alu_ready_o, lsu_ready_o);
        end
        idle();
        tick();
    endtask

    task automatic test_single_alu();
        apply_reset();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready: got %b want 1", alu_ready_o);
        end
        tick();
        idle();
        checks++;
        if (we_o !== 1'b1 || sel_rd_o !== 5'd5 || rd_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_write: we=%b sel=%0d rd=%h, want 1/5/deadbeef", we_o, sel_rd_o, rd_o);
        end
        tick();
        checks++;
        if (we_o !== 1'b0 || sel_rd_o !== 5'd5 || rd_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_idle: we=%b sel=%0d rd=%h, want 0/5/deadbeef", we_o, sel_rd_o, rd_o);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h100 + i;
            lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'h200 + i;
            #1;
            checks++;
            if (alu_ready_o !== (i % 2 == 0) || lsu_ready_o !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL contention_grant[%0d]: alu=%b lsu=%b, want %b/%b",
                         i, alu_ready_o, lsu_ready_o, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            checks++;
            if (we_o !== 1'b1 || sel_rd_o !== ((i % 2 == 0) ? 5'd1 : 5'd2) ||
                rd_o !== ((i % 2 == 0) ? 32'h100 + i : 32'h200 + i)) begin
                errors++;
                $display("FAIL contention_write[%0d]: we=%b sel=%0d rd=%h", i, we_o, sel_rd_o, rd_o);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        chk_rs1_i = 5'd7; chk_rs2_i = 5'd7;
        issue_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        idle();
        checks++;
        if (busy_rs1_o !== 1'b1 || busy_rs2_o !== 1'b1) begin
            errors++;
            $display("FAIL sb_set: busy1=%b busy2=%b, want 1/1", busy_rs1_o, busy_rs2_o);
        end
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h7A;
        tick();
        idle();
        checks++;
        if (busy_rs1_o !== 1'b1 || we_o !== 1'b1 || sel_rd_o !== 5'd7) begin
            errors++;
            $display("FAIL sb_alu_no_clear: busy=%b we=%b sel=%0d, want 1/1/7", busy_rs1_o, we_o, sel_rd_o);
        end
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
        #1;
        checks++;
        if (lsu_ready_o !== 1'b1 || busy_rs1_o !== 1'b1) begin
            errors++;
            $display("FAIL sb_lsu_cycle: ready=%b busy=%b, want 1/1", lsu_ready_o, busy_rs1_o);
        end
        tick();
        idle();
        checks++;
        if (busy_rs1_o !== 1'b0 || busy_rs2_o !== 1'b0 || we_o !== 1'b1 || rd_o !== 32'h77) begin
            errors++;
            $display("FAIL sb_clear: busy=%b/%b we=%b rd=%h, want 0/0/1/77",
                     busy_rs1_o, busy_rs2_o, we_o, rd_o);
        end
    endtask

    task automatic test_set_clear();
        apply_reset();
        chk_rs1_i = 5'd0; chk_rs2_i = 5'd9;
        issue_i = 1'b1; issue_rd_i = 5'd9;
        tick();
        issue_i = 1'b1; issue_rd_i = 5'd9;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
        tick();
        idle();
        checks++;
        if (busy_rs2_o !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: busy=%b want 1", busy_rs2_o);
        end
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h98;
        tick();
        idle();
        checks++;
        if (busy_rs2_o !== 1'b0) begin
            errors++;
            $display("FAIL later_clear: busy=%b want 0", busy_rs2_o);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h55;
        tick();
        alu_rd_i = 5'd0; alu_data_i = 32'h1234;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b want 1", alu_ready_o);
        end
        tick();
        idle();
        checks++;
        if (we_o !== 1'b0 || sel_rd_o !== 5'd3 || rd_o !== 32'h55) begin
            errors++;
            $display("FAIL x0_write: we=%b sel=%0d rd=%h, want 0/3/55", we_o, sel_rd_o, rd_o);
        end
        issue_i = 1'b1; issue_rd_i = 5'd0;
        chk_rs1_i = 5'd0; chk_rs2_i = 5'd0;
        tick();
        idle();
        checks++;
        if (busy_rs1_o !== 1'b0 || busy_rs2_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: busy=%b/%b want 0/0", busy_rs1_o, busy_rs2_o);
        end
    endtask

    task automatic test_random();
        // Model state: last contested winner, pending loads, write port contents
        bit          m_last_alu = 1'b0;
        bit [31:0]   m_pend = '0;
        bit          m_we = 1'b0;
        bit [4:0]    m_sel = '0;
        bit [31:0]   m_data = '0;
        int          winner;   // 0 none, 1 alu, 2 lsu
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid_i && !alu_ready_o)) begin
                alu_valid_i = ($urandom_range(0, 2) != 0);
                alu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                alu_data_i  = $urandom;
            end
            if (!(lsu_valid_i && !lsu_ready_o)) begin
                lsu_valid_i = ($urandom_range(0, 2) != 0);
                lsu_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                lsu_data_i  = $urandom;
            end
            issue_i    = ($urandom_range(0, 1) == 1);
            issue_rd_i = 5'($urandom);
            chk_rs1_i  = 5'($urandom);
            chk_rs2_i  = 5'($urandom);
            #1;
            if (alu_valid_i && lsu_valid_i) winner = m_last_alu ? 2 : 1;
            else if (alu_valid_i)           winner = 1;
            else if (lsu_valid_i)           winner = 2;
            else                            winner = 0;
            checks++;
            if (alu_ready_o !== (winner == 1) || lsu_ready_o !== (winner == 2)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: alu=%b lsu=%b, want winner %0d", c, alu_ready_o, lsu_ready_o, winner);
            end
            checks++;
            if (busy_rs1_o !== m_pend[chk_rs1_i] || busy_rs2_o !== m_pend[chk_rs2_i]) begin
                errors++;
                $display("FAIL rand_busy[%0d]: busy=%b/%b want %b/%b", c, busy_rs1_o, busy_rs2_o,
                         m_pend[chk_rs1_i], m_pend[chk_rs2_i]);
            end
            if (alu_valid_i && lsu_valid_i) m_last_alu = (winner == 1);
            m_we = 1'b0;
            if (winner == 1 && alu_rd_i != 0) begin
                m_we = 1'b1; m_sel = alu_rd_i; m_data = alu_data_i;
            end
            if (winner == 2 && lsu_rd_i != 0) begin
                m_we = 1'b1; m_sel = lsu_rd_i; m_data = lsu_data_i;
            end
            if (winner == 2) m_pend[lsu_rd_i] = 1'b0;
            if (issue_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
            tick();
            checks++;
            if (we_o !== m_we || sel_rd_o !== m_sel || rd_o !== m_data) begin
                errors++;
                $display("FAIL rand_port[%0d]: we=%b sel=%0d rd=%h want %b/%0d/%h",
                         c, we_o, sel_rd_o, rd_o, m_we, m_sel, m_data);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        chk_rs1_i = '0; chk_rs2_i = '0;
        test_reset();
        test_single_alu();
        test_contention();
        test_scoreboard();
        test_set_clear();
        test_x0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
